// File: rtl/asm_pkg.sv
// ============================================================================
// Module      : asm_pkg
// Description : Shared constants, state encoding and datapath op decode for the
//               two-state (t0/t1) ASM controller/datapath pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package asm_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int COUNT_DEF = 4;
    localparam int CW_DEF    = $clog2(COUNT_DEF + 1);

    // Bit positions of the controller's one-hot state vector.
    localparam int ST_T0 = 0;
    localparam int ST_T1 = 1;

    typedef enum logic [1:0] {
        OP_HOLD    = 2'd0,
        OP_LOAD    = 2'd1,
        OP_ITER    = 2'd2,
        OP_CAPTURE = 2'd3
    } dp_op_e;

    // t0 outranks t1; once the loop is done t1 only re-captures the sum.
    function automatic dp_op_e decode_op(input logic [1:0] state, input logic status);
        dp_op_e op;
        op = OP_HOLD;
        if (state[ST_T0]) begin
            op = OP_LOAD;
        end else if (state[ST_T1]) begin
            op = status ? OP_CAPTURE : OP_ITER;
        end
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/asm_datapath_if.sv
// ============================================================================
// Module      : asm_datapath_if
// Description : Controller <-> datapath bundle: state strobes, operand, status
//               and result signals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface asm_datapath_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 3
);
    logic                  t0;
    logic                  t1;
    logic [WIDTH-1:0]      operand;
    logic                  status;
    logic [WIDTH+CW-1:0]   result;
    logic                  result_valid;
    logic                  err;

    modport master (
        output t0, t1, operand,
        input  status, result, result_valid, err
    );

    modport slave (
        input  t0, t1, operand,
        output status, result, result_valid, err
    );
endinterface

`default_nettype wire

// File: rtl/asm_loop_counter.sv
// ============================================================================
// Module      : asm_loop_counter
// Description : Loop counter R with clear/increment/saturate and R==COUNT flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module asm_loop_counter #(
    parameter int COUNT = 4,
    parameter int CW    = 3
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    input  wire logic          i_clr,
    input  wire logic          i_inc,
    output logic [CW-1:0]      o_count,
    output logic               o_status
);

    logic [CW-1:0] r_count;

    assign o_status = (r_count == CW'(COUNT));
    assign o_count  = r_count;

    // Increment stops at COUNT so a faulty extra t1 can never wrap the loop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_status) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/asm_datapath.sv
// ============================================================================
// Module      : asm_datapath
// Description : Repeated-addition datapath: result = COUNT * operand, with a
//               status flag for the controller and a sticky t0/t1 clash flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module asm_datapath
    import asm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int COUNT = COUNT_DEF,
    parameter int CW    = CW_DEF
) (
    input  wire logic       clk,
    input  wire logic       resetn,
    asm_datapath_if.slave   bus
);

    logic [1:0]          w_state;
    logic                w_status;
    logic [CW-1:0]       w_count;
    logic                w_unused_count;
    dp_op_e              w_op;

    logic [WIDTH+CW-1:0] r_acc;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH+CW-1:0] r_result;
    logic                r_valid;
    logic                r_err;

    assign w_state[ST_T0]  = bus.t0;
    assign w_state[ST_T1]  = bus.t1;
    assign w_op            = decode_op(w_state, w_status);
    assign w_unused_count  = ^w_count;

    asm_loop_counter #(
        .COUNT (COUNT),
        .CW    (CW)
    ) u_loop_counter (
        .clk      (clk),
        .resetn   (resetn),
        .i_clr    (bus.t0),
        .i_inc    (bus.t1 && !bus.t0),
        .o_count  (w_count),
        .o_status (w_status)
    );

    // Accumulator is WIDTH+CW wide, so COUNT*(2^WIDTH-1) always fits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc    <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (w_op)
                OP_LOAD: begin
                    r_acc   <= '0;
                    r_b     <= bus.operand;
                    r_valid <= 1'b0;
                end
                OP_ITER: begin
                    r_acc   <= r_acc + {{CW{1'b0}}, r_b};
                    r_valid <= 1'b0;
                end
                OP_CAPTURE: begin
                    r_result <= r_acc;
                    r_valid  <= 1'b1;
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
            if (bus.t0 && bus.t1) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.status       = w_status;
    assign bus.result       = r_result;
    assign bus.result_valid = r_valid;
    assign bus.err          = r_err;

endmodule

`default_nettype wire
